// File: rtl/ct_butterfly_pipe_if.sv
// Handshake bundle for the NTT butterfly stage: triple-in channel and result-out channel.
// The master drives triples and consumes results; the slave is the butterfly stage.
interface ct_butterfly_pipe_if #(parameter int W = 12);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] in_w;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_hi;
    logic [W-1:0] out_lo;

    modport master (
        output in_valid, in_a, in_b, in_w, out_ready,
        input  in_ready, out_valid, out_hi, out_lo
    );

    modport slave (
        input  in_valid, in_a, in_b, in_w, out_ready,
        output in_ready, out_valid, out_hi, out_lo
    );
endinterface

// File: rtl/ct_butterfly_pipe.sv
// Cooley-Tukey butterfly for Kyber (q = 3329): (a, b, w) -> (a + bw, a - bw) mod q,
// with a credit-guarded output FIFO because the multiplier register never stalls.
module modmul_xing #(
    parameter int Q = 3329,
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r
);
    localparam logic [2*W-1:0] QW = (2*W)'(Q);

    logic [2*W-1:0] prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prod <= '0;
        else     prod <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end

    assign r = W'(prod % QW);
endmodule

module ct_butterfly_pipe #(
    parameter int Q     = 3329,
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input logic                 clk,
    input logic                 rst,
    ct_butterfly_pipe_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [W:0] QX = (W+1)'(Q);

    logic           accept;
    logic [W-1:0]   mul_b;
    logic [W-1:0]   mul_w;
    logic [W-1:0]   t;
    logic [W-1:0]   a_d1;
    logic           v1;
    logic           v2;
    logic [W-1:0]   hi_d2;
    logic [W-1:0]   lo_d2;
    logic [W:0]     a_x;
    logic [W:0]     t_x;
    logic [W:0]     sum;
    logic [W-1:0]   hi_c;
    logic [W-1:0]   lo_c;
    logic [W-1:0]   mem_hi [DEPTH];
    logic [W-1:0]   mem_lo [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [AW+1:0]  committed;
    logic           pop;

    // Items in the two pipeline stages already own a FIFO slot, so the FIFO cannot overflow.
    assign committed    = (AW+2)'(count) + (AW+2)'(v1) + (AW+2)'(v2);
    assign bus.in_ready = committed < (AW+2)'(DEPTH);
    assign accept       = bus.in_valid && bus.in_ready;
    assign mul_b        = accept ? bus.in_b : '0;
    assign mul_w        = accept ? bus.in_w : '0;

    modmul_xing #(.Q(Q), .W(W)) u_mul (
        .clk (clk),
        .rst (rst),
        .a   (mul_b),
        .b   (mul_w),
        .r   (t)
    );

    always_comb begin
        a_x  = {1'b0, a_d1};
        t_x  = {1'b0, t};
        sum  = a_x + t_x;
        hi_c = (sum >= QX) ? W'(sum - QX) : sum[W-1:0];
        lo_c = (a_x >= t_x) ? W'(a_x - t_x) : W'(a_x + QX - t_x);
    end

    // a is delayed one cycle to line up with the multiplier's product register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_d1  <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            hi_d2 <= '0;
            lo_d2 <= '0;
        end else begin
            v1    <= accept;
            v2    <= v1;
            hi_d2 <= hi_c;
            lo_d2 <= lo_c;
            if (accept) a_d1 <= bus.in_a;
        end
    end

    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_valid = (count != '0);
    assign bus.out_hi    = mem_hi[rd_ptr];
    assign bus.out_lo    = mem_lo[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_hi[i] <= '0;
                mem_lo[i] <= '0;
            end
        end else begin
            if (v2) begin
                mem_hi[wr_ptr] <= hi_d2;
                mem_lo[wr_ptr] <= lo_d2;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (v2 && !pop)      count <= count + 1'b1;
            else if (!v2 && pop) count <= count - 1'b1;
        end
    end
endmodule

// File: doc/ct_butterfly_pipe.md
Name: ct_butterfly_pipe

Overview:
- Cooley-Tukey NTT butterfly stage for Kyber (q = 3329). It consumes the product of the existing 12-bit modular multiplier `modmul_xing`.
- Accepts (a, b, w) triples over a valid/ready handshake and issues b, w to an internal `modmul_xing` instance.
- Aligns a with the product t = b*w mod q and produces (a+t mod q, a-t mod q).
- A credit-controlled output FIFO absorbs downstream backpressure, because the multiplier pipeline register cannot be stalled.

Parameters:
- Q, 3329, modulus; must match the reduction inside `modmul_xing`.
- DEPTH, 4, output FIFO entries; power of two, minimum 2.
- W, 12, coefficient width; fixed by `modmul_xing`, not for override.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  triple on in_a/in_b/in_w is valid.
- in_ready  output  1  stage can accept a triple this cycle.
- in_a  input  W  butterfly top operand, 0..Q-1.
- in_b  input  W  butterfly bottom operand, 0..Q-1.
- in_w  input  W  twiddle factor, 0..Q-1.
- out_valid  output  1  FIFO head holds a result.
- out_ready  input  1  consumer takes the head this cycle.
- out_hi  output  W  (a + t) mod Q.
- out_lo  output  W  (a - t) mod Q.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset state: all registers clear.
  - in_ready = 1 after reset deasserts.
  - out_valid = 0, out_hi = 0, out_lo = 0.
  - FIFO pointers = 0, count = 0.
  - In-flight valid bits = 0.
- Accept: a triple is accepted when in_valid && in_ready.
- Multiplier operands: `modmul_xing` operands are in_b/in_w when accepted, else 0. Its internal register runs every cycle.
- Pipeline:
  - Cycle 0: accept. Register in_a into a_d1 and set v1 = 1.
  - Cycle 1: `modmul_xing` R = t = (b*w) mod Q, combinational from its product register. Compute hi/lo from a_d1 and R, register them into stage 2 with v2 = v1.
  - Cycle 2: if v2, write {hi, lo} into the FIFO.
  - Result is visible at out_valid/out_hi/out_lo no earlier than cycle 3 after accept, when the FIFO is empty and out_ready is held.
- Arithmetic (all widths W+1 internally):
  - s = a + t; hi = (s >= Q) ? s - Q : s.
  - lo = (a >= t) ? a - t : a + Q - t.
  - Operands >= Q are out of contract; no checking is done.
- Credit rule: in_ready = (count + v1 + v2) < DEPTH.
  - count is FIFO occupancy; v1 and v2 count as committed slots.
  - This guarantees a FIFO slot for every in-flight item, so the FIFO never overflows.
  - in_ready is registered-free combinational from state only. It must not depend on in_valid or out_ready.
- FIFO:
  - First-in first-out. Order is strictly preserved.
  - Simultaneous write and pop leaves count unchanged.
  - Pop only when out_valid && out_ready.
  - out_valid = (count != 0).
  - out_hi/out_lo show the head entry, and hold it stably while out_valid && !out_ready.
  - Pointers wrap modulo DEPTH.
- Throughput: one triple per cycle sustained while out_ready = 1.
- Reset mid-operation: in-flight items and FIFO contents are discarded, with no spurious out_valid after reset.
- The stage holds no state machine beyond the valid shift chain, FIFO pointers and count.

Test Plan:
- Reset: rst pulsed asynchronously between clock edges -> out_valid = 0, out_hi = 0, out_lo = 0 and in_ready = 1 immediately. No output appears for 10 cycles with in_valid = 0.
- Basic: a=5, b=2, w=3, out_ready=1 -> 3 cycles later out_valid=1, out_hi=11, out_lo=3328.
- Wrap-around:
  - a=3000, b=1000, w=1 -> out_hi=671, out_lo=2000.
  - a=0, b=3328, w=3328 -> out_hi=1, out_lo=3328.
- Streaming: 64 random in-range triples back-to-back with out_ready=1 -> in_ready is never deasserted, and outputs arrive one per cycle in order, matching the software model.
- Backpressure:
  - out_ready=0 with in_valid held -> exactly DEPTH=4 triples accepted, then in_ready=0. out_hi/out_lo stay stable on the head.
  - Releasing out_ready -> all 4 results drain in order, and new accepts resume with no loss or duplication.
- Mid-flight reset: accept 3 triples, assert rst the cycle after the third -> no result ever emerges. A fresh triple after reset yields only its own correct result.
